fetch_sequencer: RTL and testbench

Multi-cycle fetch controller for the Y86-64 SEQ core. It owns a single-port, byte-wide instruction memory and reads one instruction at a time, starting at a PC supplied by the PC-update logic. It assembles icode/ifun/rA/rB/valC, computes valP, and hands the decoded fields to decode over a valid/ready handshake. Halt, invalid-instruction and memory-error conditions are sticky until reset.

---
 rtl/fetch_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Multi-cycle Y86-64 fetch controller: reads one instruction byte-by-byte from a
// byte-wide memory, assembles the decoded fields and hands them to decode.
module fetch_sequencer #(
    parameter logic [63:0] MEM_LAST = 64'd255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pc_valid,
    input  logic [63:0] pc_in,
    output logic        pc_ready,
    output logic        mem_rd_en,
    output logic [63:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        halt,
    output logic        invalid_instr,
    output logic        mem_error
);

    localparam int unsigned AW = 64;
    localparam int unsigned KW = 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_CAP    = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    // Instruction length in bytes from icode; undefined icodes are one byte.
    function automatic logic [KW-1:0] len_of(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h6, 4'hA, 4'hB: len_of = 4'd2;
            4'h7, 4'h8:             len_of = 4'd9;
            4'h3, 4'h4, 4'h5:       len_of = 4'd10;
            default:                len_of = 4'd1;
        endcase
    endfunction

    logic [2:0]    state, nxt_state;
    logic [AW-1:0] pc_q, nxt_pc;
    logic [KW-1:0] k_q, nxt_k;
    logic [KW-1:0] len_q, nxt_len;

    logic [3:0]    nxt_icode, nxt_ifun, nxt_ra, nxt_rb;
    logic [AW-1:0] nxt_valc, nxt_valp;
    logic          nxt_halt, nxt_invalid, nxt_mem_error;
    logic          nxt_out_valid, nxt_pc_ready, nxt_rd_en;
    logic [AW-1:0] nxt_addr;

    logic [KW-1:0] k_new, len_new, vc_idx;
    logic [AW-1:0] addr_req, fetch_addr;

    // Next-state and next-output logic
    always_comb begin
        nxt_state     = state;
        nxt_pc        = pc_q;
        nxt_k         = k_q;
        nxt_len       = len_q;
        nxt_icode     = icode;
        nxt_ifun      = ifun;
        nxt_ra        = rA;
        nxt_rb        = rB;
        nxt_valc      = valC;
        nxt_valp      = valP;
        nxt_halt      = halt;
        nxt_invalid   = invalid_instr;
        nxt_mem_error = mem_error;
        nxt_rd_en     = 1'b0;
        nxt_addr      = '0;
        k_new         = k_q + 4'd1;
        len_new       = len_q;
        vc_idx        = '0;
        addr_req      = pc_q + AW'(k_q);

        case (state)
            S_IDLE: begin
                if (pc_valid) begin
                    nxt_state     = S_REQ;
                    nxt_pc        = pc_in;
                    nxt_k         = '0;
                    nxt_len       = 4'd1;
                    nxt_icode     = '0;
                    nxt_ifun      = '0;
                    nxt_ra        = 4'hF;
                    nxt_rb        = 4'hF;
                    nxt_valc      = '0;
                    // Cleared icode is 0 (length 1) until byte 0 arrives.
                    nxt_valp      = pc_in + 64'd1;
                    nxt_halt      = 1'b0;
                    nxt_invalid   = 1'b0;
                    nxt_mem_error = 1'b0;
                end
            end
            S_REQ: begin
                if (addr_req > MEM_LAST) begin
                    nxt_mem_error = 1'b1;
                    nxt_state     = S_DONE;
                end else begin
                    nxt_state = S_CAP;
                end
            end
            S_CAP: begin
                if (k_q == 4'd0) begin
                    len_new     = len_of(mem_rdata[7:4]);
                    nxt_icode   = mem_rdata[7:4];
                    nxt_ifun    = mem_rdata[3:0];
                    nxt_len     = len_new;
                    nxt_valp    = pc_q + AW'(len_new);
                    nxt_halt    = (mem_rdata[7:4] == 4'h0);
                    nxt_invalid = (mem_rdata[7:4] >= 4'hC);
                end else if (k_q == 4'd1 && (len_q == 4'd2 || len_q == 4'd10)) begin
                    nxt_ra = mem_rdata[7:4];
                    nxt_rb = mem_rdata[3:0];
                end else begin
                    // Constant bytes start at byte 2 when a register byte precedes them.
                    vc_idx   = (len_q == 4'd10) ? (k_q - 4'd2) : (k_q - 4'd1);
                    nxt_valc = valC | (AW'(mem_rdata) << {vc_idx[2:0], 3'b000});
                end
                nxt_k     = k_new;
                nxt_state = (k_new < len_new) ? S_REQ : S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    nxt_state = (halt || invalid_instr || mem_error) ? S_HALTED : S_IDLE;
                end
            end
            S_HALTED: nxt_state = S_HALTED;
            default:  nxt_state = S_IDLE;
        endcase

        nxt_pc_ready  = (nxt_state == S_IDLE);
        nxt_out_valid = (nxt_state == S_DONE);
        // The read strobe is registered, so it is decided when entering REQ.
        fetch_addr    = nxt_pc + AW'(nxt_k);
        if (nxt_state == S_REQ && fetch_addr <= MEM_LAST) begin
            nxt_rd_en = 1'b1;
            nxt_addr  = fetch_addr;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            pc_q          <= '0;
            k_q           <= '0;
            len_q         <= 4'd1;
            icode         <= '0;
            ifun          <= '0;
            rA            <= 4'hF;
            rB            <= 4'hF;
            valC          <= '0;
            valP          <= '0;
            halt          <= 1'b0;
            invalid_instr <= 1'b0;
            mem_error     <= 1'b0;
            out_valid     <= 1'b0;
            pc_ready      <= 1'b1;
            mem_rd_en     <= 1'b0;
            mem_addr      <= '0;
        end else begin
            state         <= nxt_state;
            pc_q          <= nxt_pc;
            k_q           <= nxt_k;
            len_q         <= nxt_len;
            icode         <= nxt_icode;
            ifun          <= nxt_ifun;
            rA            <= nxt_ra;
            rB            <= nxt_rb;
            valC          <= nxt_valc;
            valP          <= nxt_valp;
            halt          <= nxt_halt;
            invalid_instr <= nxt_invalid;
            mem_error     <= nxt_mem_error;
            out_valid     <= nxt_out_valid;
            pc_ready      <= nxt_pc_ready;
            mem_rd_en     <= nxt_rd_en;
            mem_addr      <= nxt_addr;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed instructions with hand-computed
// expected fields; a negedge monitor checks every handoff and its latency.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pc_valid;
    logic [63:0] pc_in;
    logic        pc_ready;
    logic        mem_rd_en;
    logic [63:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic        halt, invalid_instr, mem_error;

    fetch_sequencer dut (
        .clk(clk), .reset_n(reset_n), .pc_valid(pc_valid), .pc_in(pc_in),
        .pc_ready(pc_ready), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
        .halt(halt), .invalid_instr(invalid_instr), .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic [2:0]  flags;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [7:0] mem [0:255];

    // Byte-wide memory with one-cycle read latency
    always @(posedge clk) begin
        cyc <= cyc + 1;
        mem_rdata <= mem_rd_en ? mem[mem_addr[7:0]] : 8'h00;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: handshake time, output latency, fields at handoff, strobe spacing
    int   accept_cyc = 0;
    logic prev_ov = 1'b0;
    logic prev_rd = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_ov = 1'b0;
            prev_rd = 1'b0;
        end else begin
            if (pc_valid && pc_ready) accept_cyc = cyc;
            if (mem_rd_en) chk("rd_en_spacing", 64'(prev_rd), 64'd0);
            if (out_valid && !prev_ov) begin
                if (exp_q.size() == 0) chk("unexpected_out_valid", 64'd1, 64'd0);
                else chk("latency", 64'(cyc - accept_cyc - 1), 64'(exp_q[0].lat));
            end
            if (out_valid && out_ready && exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("icode", 64'(icode), 64'(e.icode));
                chk("ifun", 64'(ifun), 64'(e.ifun));
                chk("rA_rB", 64'({rA, rB}), 64'({e.ra, e.rb}));
                chk("valC", valC, e.valc);
                chk("valP", valP, e.valp);
                chk("flags", 64'({halt, invalid_instr, mem_error}), 64'(e.flags));
            end
            prev_ov = out_valid;
            prev_rd = mem_rd_en;
        end
    end

    task automatic push(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp,
                        input logic [2:0] fl, input int lat);
        exp_t e;
        e.icode = ic; e.ifun = fn; e.ra = ra; e.rb = rb;
        e.valc = vc; e.valp = vp; e.flags = fl; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [63:0] pc);
        int n = 0;
        while (!pc_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!pc_ready) chk("pc_ready_timeout", 64'd0, 64'd1);
        pc_valid = 1'b1;
        pc_in    = pc;
        @(posedge clk); #1;
        pc_valid = 1'b0;
    endtask

    task automatic wait_handoff();
        int n = 0;
        do begin
            @(negedge clk); n++;
        end while (!(out_valid && out_ready) && n < 100);
        if (!(out_valid && out_ready)) chk("handoff_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic load(input int base, input logic [7:0] b [10], input int n);
        for (int i = 0; i < n; i++) mem[base + i] = b[i];
    endtask

    initial begin
        logic [7:0] b [10];
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        pc_valid = 1'b0; pc_in = '0; out_ready = 1'b1; reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
        chk("rst_rA_rB", 64'({rA, rB}), 64'hFF);
        chk("rst_valP", valP, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_pc_ready", 64'(pc_ready), 64'd1);

        // irmovq
        b = '{8'h30, 8'hF3, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        load(16, b, 10);
        push(4'h3, 4'h0, 4'hF, 4'h3, 64'h0102030405060708, 64'h1A, 3'b000, 20);
        issue(64'h10);
        wait_handoff();
        chk("idle_after_irmovq", 64'(pc_ready), 64'd1);

        // nop then OPq
        b = '{8'h10, 8'h60, 8'h12, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
        load(0, b, 3);
        push(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 3'b000, 2);
        push(4'h6, 4'h0, 4'h1, 4'h2, 64'd0, 64'd3, 3'b000, 4);
        issue(64'h0);
        wait_handoff();
        issue(64'h1);
        wait_handoff();

        // Backpressure on cmovXX
        b = '{8'h20, 8'hAB, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
        load(64, b, 2);
        push(4'h2, 4'h0, 4'hA, 4'hB, 64'd0, 64'h42, 3'b000, 4);
        out_ready = 1'b0;
        issue(64'h40);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold", {44'd0, out_valid, mem_rd_en, pc_ready, 1'b0, icode, rA, rB},
                {44'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2, 4'hA, 4'hB});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", 64'(out_valid), 64'd0);

        // halt then a ignored PC offer
        mem[80] = 8'h00;
        push(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h51, 3'b100, 2);
        issue(64'h50);
        wait_handoff();
        pc_valid = 1'b1; pc_in = 64'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halted_quiet", {61'd0, pc_ready, out_valid, mem_rd_en}, 64'd0);
        end
        @(posedge clk); #1;
        pc_valid = 1'b0;

        // invalid instruction
        do_reset();
        mem[96] = 8'hC0;
        push(4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'h61, 3'b010, 2);
        issue(64'h60);
        wait_handoff();
        @(negedge clk);
        chk("invalid_halted", 64'(pc_ready), 64'd0);

        // memory error on call at the top of memory
        do_reset();
        b = '{8'h80, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h0, 8'h0, 8'h0, 8'h0};
        load(250, b, 6);
        push(4'h8, 4'h0, 4'hF, 4'hF, 64'h0000005544332211, 64'd259, 3'b001, 13);
        issue(64'd250);
        wait_handoff();
        @(negedge clk);
        chk("memerr_halted", 64'(pc_ready), 64'd0);

        // reset during CAP of byte 4 of rmmovq, then a clean refetch
        do_reset();
        b = '{8'h40, 8'h12, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        load(112, b, 10);
        issue(64'h70);
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!(mem_rd_en && mem_addr == 64'h74) && n < 50);
        chk("byte4_request", mem_addr, 64'h74);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_outputs", {60'd0, out_valid, mem_rd_en, 2'b00}, 64'd0);
        chk("midrst_rA_rB", 64'({rA, rB}), 64'hFF);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_pc_ready", 64'(pc_ready), 64'd1);
        push(4'h4, 4'h0, 4'h1, 4'h2, 64'h0123456789ABCDEF, 64'h7A, 3'b000, 20);
        issue(64'h70);
        wait_handoff();

        repeat (4) @(posedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
